// File: rtl/adder_8bit_unit.sv
// adder_8bit_unit
// Registered WIDTH-bit adder with carry-in, carry-out, signed overflow and
// zero flags. The sum is formed by a ripple chain of full-adder cells; all
// results are captured on a rising clk when in_valid is high, giving a fixed
// one-cycle latency with a matching out_valid strobe.

module adder_8bit_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             overflow_c;
    logic             zero_c;

    assign carry[0] = cin;

    // Ripple-carry chain of full-adder cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic prop;
        assign prop         = a[i] ^ b[i];
        assign sum_c[i]     = prop ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & prop);
    end

    // Status flags derived from the full-width carry chain.
    always_comb begin
        cout_c     = carry[WIDTH];
        overflow_c = carry[WIDTH - 1] ^ carry[WIDTH];
        zero_c     = ~|sum_c;
    end

    // Output stage: capture on in_valid, otherwise hold; out_valid follows in_valid.
    // Capture is gated so undriven operands while idle never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_c;
                cout     <= cout_c;
                overflow <= overflow_c;
                zero     <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_adder_8bit_unit.sv
// Directed bench for adder_8bit_unit. Outputs are packed as
// {out_valid, cout, overflow, zero, sum} and compared against hand-computed values.

module tb_adder_8bit_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;
    logic       zero;
    logic       out_valid;

    int n_cmp;
    int n_err;

    adder_8bit_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {out_valid, cout, overflow, zero, sum};
    endfunction

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state got=%h want=%h", obs(), 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_err++;
            $display("FAIL reset_release got=%h want=%h", obs(), 12'h000);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  va [4] = '{8'h0D, 8'h0D, 8'h8D, 8'hFF};
        logic [7:0]  vb [4] = '{8'h02, 8'h02, 8'h22, 8'h82};
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        // {out_valid, cout, overflow, zero, sum}
        logic [11:0] ve [4] = '{12'h80F, 12'h810, 12'h8AF, 12'hC81};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== ve[i]) begin
                n_err++;
                $display("FAIL basic_%0d got=%h want=%h", i, obs(), ve[i]);
            end
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [7:0]  va [4] = '{8'h7F, 8'hFF, 8'h80, 8'h00};
        logic [7:0]  vb [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [11:0] ve [4] = '{12'hA80, 12'hD00, 12'hF00, 12'h900};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== ve[i]) begin
                n_err++;
                $display("FAIL ovf_zero_%0d got=%h want=%h", i, obs(), ve[i]);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        drive(8'hFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'hCFF) begin
            n_err++;
            $display("FAIL wrap_max got=%h want=%h", obs(), 12'hCFF);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3] = '{8'h01, 8'h7F, 8'hF0};
        logic [7:0]  vb [3] = '{8'h02, 8'h7F, 8'h10};
        logic        vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [11:0] ve [3] = '{12'h803, 12'hAFF, 12'hD00};
        drive(va[0], vb[0], vc[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== ve[i]) begin
                n_err++;
                $display("FAIL b2b_%0d got=%h want=%h", i, obs(), ve[i]);
            end
            if (i < 2) drive(va[i + 1], vb[i + 1], vc[i + 1]);
        end
        idle();
    endtask

    task automatic test_hold_x();
        drive(8'h12, 8'h34, 1'b1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'h847) begin
            n_err++;
            $display("FAIL hold_load got=%h want=%h", obs(), 12'h847);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hxx;
        b        = 8'hzz;
        cin      = 1'bx;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== 12'h047) begin
                n_err++;
                $display("FAIL hold_x_%0d got=%h want=%h", i, obs(), 12'h047);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(8'h20, 8'h30, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 12'h850) begin
            n_err++;
            $display("FAIL mid_pre got=%h want=%h", obs(), 12'h850);
        end
        drive(8'h40, 8'h01, 1'b1);
        // Pulse reset between edges with a new operand pending.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
            n_err++;
            $display("FAIL mid_async got=%h want=%h", obs(), 12'h000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hxx;
        b        = 8'hxx;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== 12'h000) begin
                n_err++;
                $display("FAIL mid_after_%0d got=%h want=%h", i, obs(), 12'h000);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_hold_x();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
